mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage placed directly downstream of the execute stage. It registers the execute-stage results and runs loads and stores through a request/acknowledge handshake to data memory. Loads return data sign- or zero-extended by width, and the stage stalls the pipeline while an access is outstanding. Its registered ALU result is the `alu_resultm` forwarding source for execute. All its registered outputs feed the write-back stage.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath width; only 32 is supported.
- `ADDR_WIDTH`, 32, byte address width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `reg_wee` input 1: register-write enable from execute.
- `ope` input 3: access width/sign (funct3).
- `mem_wee` input 1: store enable.
- `rde` input 5: destination register.
- `pcne` input ADDR_WIDTH: pc+4.
- `alu_result` input DATA_WIDTH: effective address or ALU value.
- `rd2_ture` input DATA_WIDTH: forwarded store data.
- `wb_ctre` input 2: write-back select; 00 = ALU, 01 = memory (load), 10 = pc+4.
- `flush` input 1: inserts a bubble instead of capturing the execute outputs.
- `reg_wem`, `mem_wem`, `rdm`, `pcnm`, `alu_resultm`, `wb_ctrm`, `opm` output: registered copies of the corresponding inputs.
- `mem_rdatam` output DATA_WIDTH: extended load data, registered.
- `stall_mem` output 1: freezes PC, decode, execute and this stage's input register.
- `dmem_req` output 1: access request.
- `dmem_we` output 1: 1 = write.
- `dmem_addr` output ADDR_WIDTH: word-aligned address, `{alu_resultm[31:2],2'b00}`.
- `dmem_wdata` output DATA_WIDTH: store data shifted into byte lanes.
- `dmem_be` output 4: byte enables.
- `dmem_ack` input 1: access complete; read data is valid in the same cycle.
- `dmem_rdata` input DATA_WIDTH: raw read word.
- `misalign` output 1: present only when `MEM_MISALIGN_CHK_EN` is defined.

## Operation
- Input register:
  - On each clock edge with `stall_mem`=0, it captures all execute outputs.
  - If `flush`=1 at that edge, it loads a bubble: `reg_wem`=0, `mem_wem`=0, `wb_ctrm`=00, `rdm`=0.
  - `stall_mem` takes priority over `flush`.
- Access condition: `access` = `mem_wem` | (`wb_ctrm`==01).
- State machine states: IDLE, WAIT, DONE.
  - IDLE, `access`=0: pass-through; no request; `stall_mem`=0.
  - IDLE, `access`=1: `dmem_req`=1; `stall_mem`=1; next state WAIT.
  - WAIT: `dmem_req`=1 and `stall_mem`=1. On `dmem_ack`, the extended load value is captured into `mem_rdatam` (stores leave it unchanged) and the next state is DONE.
  - DONE: `dmem_req`=0, `stall_mem`=0. The input register advances at this edge; next state IDLE.
- Byte lanes use `a` = `alu_resultm[1:0]`:
  - `ope` 000/100 (byte): `dmem_be` = 1<<a; write data is replicated to all four bytes.
  - `ope` 001/101 (half): `dmem_be` = 0011<<a; write data is replicated to both halves.
  - `ope` 010 (word): `dmem_be` = 1111.
  - Reads assert `dmem_be` the same way.
- Load extension: select the addressed byte or half from `dmem_rdata`.
  - `ope` 000/001: sign-extend.
  - `ope` 100/101: zero-extend.
  - `ope` 010: whole word.
- While `dmem_req`=1, `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_be` are held stable.

## Timing
- All outputs reset to 0, and the state machine resets to IDLE.
- Reset asserted mid-access: `dmem_req` drops immediately (asynchronously). Memory must tolerate an abandoned request.
- Non-access instruction: 1 cycle in the stage.
- Access: a minimum of 3 cycles (IDLE, WAIT, DONE) when `dmem_ack` arrives in the first WAIT cycle. Each additional wait cycle adds 1.
- `dmem_ack` is ignored in IDLE and DONE.
- `mem_rdatam` is valid from the DONE cycle and holds until the next load's acknowledge.
- `alu_resultm` is stable throughout the stall, so forwarding stays valid.

## Configuration
- `MEM_MISALIGN_CHK_EN` defined:
  - A halfword access with `a[0]`=1, or a word access with `a`≠00, never requests memory.
  - The state machine stays in IDLE and `stall_mem`=0.
  - `misalign` goes high for that instruction's cycle.
  - `mem_rdatam` is not updated, and `reg_wem` is forced to 0 for that instruction.
- `MEM_MISALIGN_CHK_EN` undefined: the `misalign` port is absent. Misaligned addresses are issued with the lane masks above, and the enables may truncate.

## Test plan
- ALU op, `alu_result`=0x1234, `wb_ctre`=00 -> one cycle later `alu_resultm`=0x1234, no `dmem_req`, `stall_mem`=0.
- SW at 0x100, data 0xDEADBEEF, ack after 2 wait cycles -> `dmem_be`=1111 and `dmem_we`=1 held for 3 cycles; `stall_mem` high for 3 cycles, then DONE.
- LB at 0x103, `dmem_rdata`=0x80FF_FF00 -> `mem_rdatam`=0xFFFFFF80. The same access as LBU -> 0x00000080.
- SH at 0x102, data 0x0000ABCD -> `dmem_be`=1100, `dmem_wdata`=0xABCDABCD.
- `rst` pulsed low during WAIT -> `dmem_req`=0 and all outputs 0 within the same cycle; state IDLE after release.
- With `MEM_MISALIGN_CHK_EN`, LW at 0x101 -> `misalign`=1, no `dmem_req`, `reg_wem`=0, no stall.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
//==============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage sitting directly after execute.
//               Registers the execute results and runs loads/stores through a
//               req/ack handshake to data memory. Load data is sign- or
//               zero-extended by access width. The stage raises stall_mem
//               while an access is outstanding. alu_resultm is the forwarding
//               source for execute; all registered outputs feed write-back.
//
// Ports       : clk, rst (async, active-low)
//               execute side : reg_wee, ope, mem_wee, rde, pcne, alu_result,
//                              rd2_ture, wb_ctre, flush
//               write-back   : reg_wem, mem_wem, rdm, pcnm, alu_resultm,
//                              wb_ctrm, opm, mem_rdatam
//               pipeline     : stall_mem
//               data memory  : dmem_req, dmem_we, dmem_addr, dmem_wdata,
//                              dmem_be, dmem_ack, dmem_rdata
//               optional     : misalign
//
// Options     : MEM_MISALIGN_CHK_EN - when defined, misaligned halfword/word
//               accesses are suppressed and flagged on the misalign port.
//
// Revision    : 1.0 - initial release
//==============================================================================
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_wee,
    input  logic [2:0]            ope,
    input  logic                  mem_wee,
    input  logic [4:0]            rde,
    input  logic [ADDR_WIDTH-1:0] pcne,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] rd2_ture,
    input  logic [1:0]            wb_ctre,
    input  logic                  flush,
    output logic                  reg_wem,
    output logic                  mem_wem,
    output logic [4:0]            rdm,
    output logic [ADDR_WIDTH-1:0] pcnm,
    output logic [DATA_WIDTH-1:0] alu_resultm,
    output logic [1:0]            wb_ctrm,
    output logic [2:0]            opm,
    output logic [DATA_WIDTH-1:0] mem_rdatam,
    output logic                  stall_mem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic                  misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Input (execute -> memory) register
    logic                  r_reg_we;
    logic                  r_mem_we;
    logic [4:0]            r_rd;
    logic [ADDR_WIDTH-1:0] r_pcn;
    logic [DATA_WIDTH-1:0] r_alu;
    logic [DATA_WIDTH-1:0] r_rd2;
    logic [1:0]            r_wb_ctr;
    logic [2:0]            r_ope;
    logic [DATA_WIDTH-1:0] r_rdata;

    state_t r_state;
    state_t w_state_nxt;

    logic                  w_req;
    logic                  w_stall;
    logic                  w_access;
    logic                  w_is_load;
    logic                  w_misalign;
    logic                  w_rdata_cap;
    logic [1:0]            w_a;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_a       = r_alu[1:0];
    assign w_access  = r_mem_we | (r_wb_ctr == 2'b01);
    assign w_is_load = (r_wb_ctr == 2'b01) & ~r_mem_we;

    // ope[1] selects word, ope[0] selects half, otherwise byte.
`ifdef MEM_MISALIGN_CHK_EN
    assign w_misalign = w_access &
                        ((r_ope[1] & (w_a != 2'b00)) |
                         (~r_ope[1] & r_ope[0] & w_a[0]));
    assign misalign   = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Access state machine
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A suppressed misaligned access behaves like a pass-through.
                if (w_access && !w_misalign) begin
                    w_req       = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (dmem_ack) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Input register: held while stalled; flush inserts a bubble.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_we <= 1'b0;
            r_mem_we <= 1'b0;
            r_rd     <= '0;
            r_pcn    <= '0;
            r_alu    <= '0;
            r_rd2    <= '0;
            r_wb_ctr <= 2'b00;
            r_ope    <= 3'b000;
        end else if (!w_stall) begin
            r_pcn <= pcne;
            r_alu <= alu_result;
            r_rd2 <= rd2_ture;
            r_ope <= ope;
            if (flush) begin
                r_reg_we <= 1'b0;
                r_mem_we <= 1'b0;
                r_rd     <= '0;
                r_wb_ctr <= 2'b00;
            end else begin
                r_reg_we <= reg_wee;
                r_mem_we <= mem_wee;
                r_rd     <= rde;
                r_wb_ctr <= wb_ctre;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Byte lanes and store data replication
    //--------------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_rd2;
        if (!r_ope[1]) begin
            if (r_ope[0]) begin
                // Shift truncates to 4 bits for a misaligned half at a=3.
                w_be    = 4'b0011 << w_a;
                w_wdata = {2{r_rd2[15:0]}};
            end else begin
                w_be    = 4'b0001 << w_a;
                w_wdata = {4{r_rd2[7:0]}};
            end
        end
    end

    //--------------------------------------------------------------------------
    // Load extraction and extension
    //--------------------------------------------------------------------------
    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (w_a)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
    end

    // Half selection uses only a[1]; a misaligned half reads its aligned half.
    assign w_half = w_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_ext = dmem_rdata;
        case (r_ope)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    assign w_rdata_cap = (r_state == S_WAIT) & dmem_ack & w_is_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (w_rdata_cap) begin
            r_rdata <= w_ext;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs. Memory-side signals are zero outside a request so that the
    // bus is quiet after reset and between accesses; during a request they
    // come straight from the held input register and therefore stay stable.
    //--------------------------------------------------------------------------
    assign reg_wem     = r_reg_we & ~w_misalign;
    assign mem_wem     = r_mem_we;
    assign rdm         = r_rd;
    assign pcnm        = r_pcn;
    assign alu_resultm = r_alu;
    assign wb_ctrm     = r_wb_ctr;
    assign opm         = r_ope;
    assign mem_rdatam  = r_rdata;
    assign stall_mem   = w_stall;

    assign dmem_req    = w_req;
    assign dmem_we     = w_req & r_mem_we;
    assign dmem_addr   = w_req ? {r_alu[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dmem_wdata  = w_req ? w_wdata : '0;
    assign dmem_be     = w_req ? w_be : 4'b0000;

endmodule

`default_nettype wire
